serial2parallel_capture: RTL and testbench

//  Downstream sink for the pooled serial bitstream (serial_data/serial_valid/serial_ready_in of the pipeline top).

---
 rtl/serial2parallel_capture_if.sv | 19 +
 rtl/serial2parallel_capture.sv | 130 +++++++++++++
 tb/tb_serial2parallel_capture.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial2parallel_capture_if.sv
// Serial bit-stream handshake between the pooled-data source and the capture sink.
// A bit transfers on any clock edge where serial_valid && serial_ready_out.
interface serial2parallel_capture_if;
  logic serial_data;
  logic serial_valid;
  logic serial_ready_out;

  modport master (
    output serial_data,
    output serial_valid,
    input  serial_ready_out
  );

  modport slave (
    input  serial_data,
    input  serial_valid,
    output serial_ready_out
  );
endinterface

// File: rtl/serial2parallel_capture.sv
// Deserialises an MSB-first bit stream into bytes and writes each byte to a result memory
// at an incrementing address, pulsing frame_done when the last byte of a frame is written.
module serial2parallel_capture #(
  parameter int DATA_W       = 8,
  parameter int FRAME_PIXELS = 1024,
  parameter int ADDR_W       = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  serial2parallel_capture_if.slave ser,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_din,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIXELS - 1);

  logic [0:0]        state_q,  state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [DATA_W-1:0] shift_q,  shift_d;
  logic              ready_q,  ready_d;
  logic              busy_q,   busy_d;
  logic              we_q,     we_d;
  logic              done_q,   done_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] din_q,    din_d;
  logic [DATA_W-1:0] shifted_s;
  logic              xfer_s;

  // A transfer only happens while the registered ready is high, i.e. in RECV.
  assign xfer_s    = ser.serial_valid && ready_q;
  assign shifted_s = {shift_q[DATA_W-2:0], ser.serial_data};

  // Next-state and output computation for the capture FSM.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    pix_cnt_d = pix_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    din_d     = din_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RECV;
          bit_cnt_d = '0;
          pix_cnt_d = '0;
          shift_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (xfer_s) begin
          shift_d = shifted_s;
          if (bit_cnt_q == LAST_BIT) begin
            we_d      = 1'b1;
            din_d     = shifted_s;
            addr_d    = pix_cnt_q;
            bit_cnt_d = '0;
            pix_cnt_d = pix_cnt_q + ADDR_W'(1);
            if (pix_cnt_q == LAST_PIX) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_RECV;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_RECV;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Ready and busy are registered copies of the next state so they track state_q exactly.
    ready_d = (state_d == ST_RECV);
    busy_d  = (state_d == ST_RECV);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      pix_cnt_q <= '0;
      shift_q   <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      shift_q   <= shift_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      we_q      <= we_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
    end
  end

  assign ser.serial_ready_out = ready_q;
  assign busy                 = busy_q;
  assign mem_we               = we_q;
  assign mem_addr             = addr_q;
  assign mem_din              = din_q;
  assign frame_done           = done_q;

endmodule

// File: tb/tb_serial2parallel_capture.sv
// Directed bench for serial2parallel_capture with a 4-byte frame; a negedge monitor logs
// every memory write and frame_done pulse, and the main sequence checks them against constants.
module tb_serial2parallel_capture;
  localparam int DW = 8;
  localparam int FP = 4;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          busy;
  logic          frame_done;

  serial2parallel_capture_if ser_if ();

  serial2parallel_capture #(.DATA_W(DW), .FRAME_PIXELS(FP), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .ser        (ser_if.slave),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int done_cnt = 0;
  int done_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write / frame_done logger, sampled on the falling edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(int'(mem_din));
      wr_cyc.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      done_cnt = done_cnt + 1;
      if (mem_we !== 1'b1 || mem_addr !== AW'(FP - 1)) done_bad = done_bad + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    done_cnt = 0; done_bad = 0;
  endtask

  // Called at a negedge; returns at the negedge after the bit has transferred.
  task automatic send_bit(input logic b, input int gap);
    int t;
    ser_if.serial_valid = 1'b0;
    repeat (gap) @(negedge clk);
    ser_if.serial_data  = b;
    ser_if.serial_valid = 1'b1;
    t = 0;
    while (ser_if.serial_ready_out !== 1'b1 && t < 20) begin
      @(negedge clk);
      t = t + 1;
    end
    if (t == 20) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v, input int max_gap);
    for (int i = 7; i >= 0; i--) send_bit(v[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    ser_if.serial_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] exp_d [4];
    exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
    check({tag, "_nwrites"}, 32'(wr_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      check({tag, "_addr"}, 32'(wr_addr[i]), 32'(i));
      check({tag, "_data"}, 32'(wr_data[i]), exp_d[i]);
    end
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_bad"}, 32'(done_bad), 32'd0);
  endtask

  initial begin
    ser_if.serial_data  = 1'b1;
    ser_if.serial_valid = 1'b1;
    // Reset with valid asserted.
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ser_if.serial_ready_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_din", 32'(mem_din), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_nwrites", 32'(wr_addr.size()), 32'd0);
    reset_n = 1'b1;
    ser_if.serial_valid = 1'b0;
    @(negedge clk);

    // Continuous frame A5,3C,FF,00.
    clear_log();
    pulse_start();
    check("recv_busy", 32'(busy), 32'd1);
    check("recv_ready", 32'(ser_if.serial_ready_out), 32'd1);
    send_byte(8'hA5, 0); send_byte(8'h3C, 0); send_byte(8'hFF, 0); send_byte(8'h00, 0);
    check("last_done", 32'(frame_done), 32'd1);
    check("last_we", 32'(mem_we), 32'd1);
    check("last_ready", 32'(ser_if.serial_ready_out), 32'd0);
    check("last_busy", 32'(busy), 32'd0);
    idle(3);
    check("post_done", 32'(frame_done), 32'd0);
    check("post_we", 32'(mem_we), 32'd0);
    check_frame("cont", 32'hA5, 32'h3C, 32'hFF, 32'h00);
    if (wr_cyc.size() == 4)
      for (int i = 1; i < 4; i++) check("cont_spacing", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd8);

    // Same frame with random valid gaps, including mid-byte.
    clear_log();
    pulse_start();
    send_byte(8'hA5, 3); send_byte(8'h3C, 3); send_byte(8'hFF, 3); send_byte(8'h00, 3);
    idle(3);
    check_frame("gaps", 32'hA5, 32'h3C, 32'hFF, 32'h00);

    // Valid while IDLE without start, then a start pulse mid-frame.
    clear_log();
    ser_if.serial_valid = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_ready", 32'(ser_if.serial_ready_out), 32'd0);
    check("idle_nwrites", 32'(wr_addr.size()), 32'd0);
    ser_if.serial_valid = 1'b0;
    pulse_start();
    send_byte(8'h11, 0);
    send_bit(1'b0, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
    start = 1'b1;
    send_bit(1'b0, 0);
    start = 1'b0;
    send_bit(1'b0, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
    send_byte(8'h33, 1); send_byte(8'h44, 0);
    idle(3);
    check_frame("restart_ign", 32'h11, 32'h22, 32'h33, 32'h44);

    // Reset after 5 bits of byte 2 (third byte), then a fresh frame.
    clear_log();
    pulse_start();
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    for (int i = 7; i >= 3; i--) send_bit(1'b1, 0);
    ser_if.serial_valid = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("midrst_ready", 32'(ser_if.serial_ready_out), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_addr", 32'(mem_addr), 32'd0);
    check("midrst_nwrites", 32'(wr_addr.size()), 32'd2);
    idle(2);
    check("midrst_idle_ready", 32'(ser_if.serial_ready_out), 32'd0);
    clear_log();
    pulse_start();
    send_byte(8'h5A, 0); send_byte(8'h6B, 0); send_byte(8'h7C, 0); send_byte(8'h8D, 0);
    idle(3);
    check_frame("after_rst", 32'h5A, 32'h6B, 32'h7C, 32'h8D);

    // start held high: two frames back to back.
    clear_log();
    start = 1'b1;
    @(negedge clk);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    send_byte(8'hF1, 0); send_byte(8'hF2, 0); send_byte(8'hF3, 0); send_byte(8'hF4, 0);
    start = 1'b0;
    idle(4);
    check("b2b_nwrites", 32'(wr_addr.size()), 32'd8);
    for (int i = 0; i < 8 && i < wr_addr.size(); i++) check("b2b_addr", 32'(wr_addr[i]), 32'(i % 4));
    if (wr_data.size() == 8) begin
      check("b2b_data4", 32'(wr_data[4]), 32'hF1);
      check("b2b_data7", 32'(wr_data[7]), 32'hF4);
    end
    check("b2b_done_cnt", 32'(done_cnt), 32'd2);
    check("b2b_done_bad", 32'(done_bad), 32'd0);
    check("b2b_end_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
